edge_event_arb: RTL and testbench
=================================

Name: edge_event_arb

Overview:
- Multi-channel edge-event controller that feeds one shared event consumer.
- Each channel has a two-flop synchroniser, an edge detector with a per-channel edge-type select, and a one-deep pending slot.
- A round-robin scheduler moves pending events into one registered valid/ready output port.
- Sits between raw asynchronous status lines (buttons, interrupts) and a single downstream handler.

Parameters:
- N, 4, number of input channels (2..16).
- CW, 2, channel index width; must satisfy 2**CW >= N.

Ports:
- clk  input  1  system clock; all flops on posedge.
- rstn  input  1  asynchronous active-low reset.
- dat_i  input  N  raw channel inputs, asynchronous to clk.
- edge_sel  input  2N  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- evt_valid  output  1  event available on evt_ch/evt_rise.
- evt_ready  input  1  consumer accepts the event in this cycle.
- evt_ch  output  CW  channel index of the presented event.
- evt_rise  output  1  1 = rising edge, 0 = falling edge.
- pend_o  output  N  per-channel pending flags.
- ovf_o  output  N  sticky per-channel overflow flags.
- ovf_clr  input  1  synchronous clear of all ovf_o bits.

Interface decision: one clock; reset is asynchronous and active-low, ports named clk and rstn.

Behaviour:
- Reset: s1, s2, s3 (per-channel sync/edge flops), pending, ptype, ovf_o, evt_valid, evt_ch, evt_rise and rr_ptr are all 0.
- Consequence of reset values: a channel held high through reset release yields one rising edge if rising is enabled.
- Pipeline per channel:
  - s1 <= dat_i[i]; s2 <= s1; s3 <= s2.
  - rise_i = s2 & ~s3; fall_i = ~s2 & s3.
  - det_i = (rise_i & sel[0]) | (fall_i & sel[1]).
- Pending slot, per channel, in priority order:
  - det_i with pending clear, or with the channel being popped this cycle: pending <= 1, ptype <= rise_i.
  - det_i with pending set and not popped: event dropped, ovf_o[i] <= 1; pending and ptype unchanged.
  - Popped with no det_i: pending <= 0.
- ovf_o: ovf_clr clears all bits; a new overflow in the same cycle as ovf_clr wins (that bit stays 1).
- Output register is loadable when !evt_valid or (evt_valid & evt_ready).
- When loadable:
  - Scan pending from rr_ptr upward, wrapping at N-1 to 0.
  - First hit k: evt_valid <= 1, evt_ch <= k, evt_rise <= ptype[k], pending[k] is popped, rr_ptr <= k+1 (wraps to 0 past N-1).
  - No hit: evt_valid <= 0; evt_ch and evt_rise hold their values.
- Handshake:
  - evt_ch and evt_rise are stable while evt_valid & !evt_ready.
  - evt_valid never drops without a handshake.
  - With evt_ready held high, throughput is one event per cycle.
- Latency: dat_i transition captured at edge E0 gives evt_valid high after E3 (output empty, no contention).
- The scan uses only registered pending. An edge detected in the cycle a slot is popped is seen by the scan one cycle later.
- edge_sel changes:
  - Affect detection from the next cycle.
  - Never clear existing pending events.
  - A disabled channel (00) still delivers an event already pending.
- Channel indices >= N are never issued.
- Asynchronous reset mid-operation discards all pending events and any presented event; evt_valid drops immediately.

Test Plan:
- N=4, edge_sel=all 01, evt_ready=1, dat_i[2] 0->1 before E0 -> evt_valid=1 after E3 for one cycle, evt_ch=2, evt_rise=1; dat_i[2] 1->0 produces no event.
- edge_sel[1:0]=11, ch0 pulse high for 5 cycles, evt_ready=1 -> two events, evt_rise=1 then evt_rise=0, 5 cycles apart.
- All four channels rise in the same cycle, evt_ready=1 -> evt_ch 0,1,2,3 on consecutive cycles; next simultaneous burst starts at ch0 (rr_ptr wrapped); with rr_ptr=2 the order is 2,3,0,1.
- evt_ready=0, ch1 toggles 1,0,1 with edge_sel=11 -> first edge presented (evt_rise=1, held stable); second edge pending (evt_rise=0); third sets ovf_o[1]=1; releasing evt_ready yields exactly 2 events; ovf_clr returns ovf_o to 0.
- ovf_clr asserted in the same cycle as a new ch3 overflow -> ovf_o[3]=1 afterward.
- rstn pulsed low while evt_valid=1 with pending=4'b1010 -> evt_valid, pend_o and ovf_o are 0 immediately; no event after release unless a new edge occurs (ch held high with rising enabled gives one event).

Source files
------------

// File: rtl/edge_event_arb.sv
// Edge-event controller: per-channel sync + edge detect + one-deep pending slot,
// drained round-robin into a single registered valid/ready event port.
module edge_event_arb #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    dat_i,
    input  logic [2*N-1:0]  edge_sel,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CW-1:0]   evt_ch,
    output logic            evt_rise,
    output logic [N-1:0]    pend_o,
    output logic [N-1:0]    ovf_o,
    input  logic            ovf_clr
);

    logic [N-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [N-1:0]  pend_q, pend_d, ptype_q, ptype_d, ovf_q, ovf_d;
    logic          evt_valid_q, evt_valid_d;
    logic          evt_rise_q, evt_rise_d;
    logic [CW-1:0] evt_ch_q, evt_ch_d;
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]  rise, fall, det, pop;
    logic          load, found, hit_rise;
    logic [CW-1:0] hit;

    // Scan only registered pending: first from rr_ptr upward, then wrap from 0.
    always_comb begin
        load     = !evt_valid_q || evt_ready;
        found    = 1'b0;
        hit      = '0;
        hit_rise = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && pend_q[k] && (CW'(k) >= rr_ptr_q)) begin
                found    = 1'b1;
                hit      = CW'(k);
                hit_rise = ptype_q[k];
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && pend_q[k]) begin
                found    = 1'b1;
                hit      = CW'(k);
                hit_rise = ptype_q[k];
            end
        end
        pop = '0;
        for (int k = 0; k < N; k++) begin
            pop[k] = load && found && (hit == CW'(k));
        end
    end

    always_comb begin
        s1_d    = dat_i;
        s2_d    = s1_q;
        s3_d    = s2_q;
        rise    = '0;
        fall    = '0;
        det     = '0;
        pend_d  = pend_q;
        ptype_d = ptype_q;
        ovf_d   = ovf_clr ? '0 : ovf_q;
        for (int i = 0; i < N; i++) begin
            rise[i] = s2_q[i] & ~s3_q[i];
            fall[i] = ~s2_q[i] & s3_q[i];
            det[i]  = (rise[i] & edge_sel[2*i]) | (fall[i] & edge_sel[2*i+1]);
            // A slot being popped this cycle can accept a fresh edge without overflow.
            if (det[i] && (!pend_q[i] || pop[i])) begin
                pend_d[i]  = 1'b1;
                ptype_d[i] = rise[i];
            end else if (det[i]) begin
                ovf_d[i] = 1'b1;
            end else if (pop[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_rise_d  = evt_rise_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (found) begin
                evt_valid_d = 1'b1;
                evt_ch_d    = hit;
                evt_rise_d  = hit_rise;
                rr_ptr_d    = (hit == CW'(N-1)) ? '0 : hit + CW'(1);
            end else begin
                evt_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            pend_q      <= '0;
            ptype_q     <= '0;
            ovf_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_rise_q  <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            pend_q      <= pend_d;
            ptype_q     <= ptype_d;
            ovf_q       <= ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_rise_q  <= evt_rise_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_rise  = evt_rise_q;
    assign pend_o    = pend_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_edge_event_arb.sv
// Bench for edge_event_arb: single-edge vector table, then hand-written
// both-edge, burst/round-robin, overflow, ovf_clr race and reset sequences.
module tb_edge_event_arb;

    localparam int N  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  dat_i;
    logic [2*N-1:0] edge_sel;
    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] evt_ch;
    logic          evt_rise;
    logic [N-1:0]  pend_o;
    logic [N-1:0]  ovf_o;
    logic          ovf_clr;

    edge_event_arb #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .dat_i     (dat_i),
        .edge_sel  (edge_sel),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .pend_o    (pend_o),
        .ovf_o     (ovf_o),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   dat;
        logic [2*N-1:0] sel;
        logic           ev;
        logic [CW-1:0]  ch;
        logic           rise;
    } vec_t;

    typedef struct {
        logic [CW-1:0] ch;
        logic          rise;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[8];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [CW-1:0] ch, input logic rise);
        exp_t e;
        e.ch   = ch;
        e.rise = rise;
        sb_q.push_back(e);
    endtask

    // Every accepted event must match the next expected one, in order.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && evt_valid && evt_ready) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event actual ch=%0d rise=%0d required none at %0t",
                         evt_ch, evt_rise, $time);
            end else begin
                e = sb_q.pop_front();
                if (evt_ch !== e.ch || evt_rise !== e.rise) begin
                    n_fail++;
                    $display("FAIL event_order actual ch=%0d rise=%0d required ch=%0d rise=%0d at %0t",
                             evt_ch, evt_rise, e.ch, e.rise, $time);
                end
            end
        end
    end

    task automatic burst(input logic [7:0] order);
        dat_i = 4'hF;
        for (int j = 0; j < 4; j++) sb_push(order[2*j +: 2], 1'b1);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("burst_valid", evt_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk("burst_ch", evt_ch, order[2*(c-3) +: 2]);
        end
        dat_i = 4'h0;
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0100, 8'b01_01_01_01, 1'b1, 2'd2, 1'b1};
        tbl[1] = '{4'b0000, 8'b01_01_01_01, 1'b0, 2'd0, 1'b0};
        tbl[2] = '{4'b0001, 8'b01_01_01_10, 1'b0, 2'd0, 1'b0};
        tbl[3] = '{4'b0000, 8'b01_01_01_10, 1'b1, 2'd0, 1'b0};
        tbl[4] = '{4'b1000, 8'b11_01_01_10, 1'b1, 2'd3, 1'b1};
        tbl[5] = '{4'b0000, 8'b11_01_01_10, 1'b1, 2'd3, 1'b0};
        tbl[6] = '{4'b0010, 8'b00_00_00_00, 1'b0, 2'd0, 1'b0};
        tbl[7] = '{4'b0000, 8'b00_00_01_00, 1'b0, 2'd0, 1'b0};

        rstn      = 1'b0;
        dat_i     = '0;
        edge_sel  = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();
        chk("reset_valid", evt_valid, 0);
        chk("reset_pend", pend_o, 0);
        chk("reset_ovf", ovf_o, 0);

        // Single-edge vectors: event (if any) visible right after the 4th edge.
        for (int v = 0; v < 8; v++) begin
            edge_sel = tbl[v].sel;
            dat_i    = tbl[v].dat;
            if (tbl[v].ev) sb_push(tbl[v].ch, tbl[v].rise);
            repeat (4) step();
            chk("vec_valid", evt_valid, tbl[v].ev);
            if (tbl[v].ev) begin
                chk("vec_ch", evt_ch, tbl[v].ch);
                chk("vec_rise", evt_rise, tbl[v].rise);
            end
            repeat (2) step();
            chk("vec_pend", pend_o, 0);
        end

        // Both-edge pulse of 5 cycles: rise event then fall event 5 cycles later.
        edge_sel = 8'b00_00_00_11;
        sb_push(2'd0, 1'b1);
        sb_push(2'd0, 1'b0);
        dat_i = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) dat_i = 4'b0000;
            step();
            chk("pulse_valid", evt_valid, (c == 3 || c == 8));
            if (c == 3) chk("pulse_rise1", evt_rise, 1);
            if (c == 8) chk("pulse_rise0", evt_rise, 0);
        end

        // Park rr_ptr at 0 via a ch3 event, then bursts.
        edge_sel = 8'b01_01_01_01;
        dat_i = 4'b1000;
        sb_push(2'd3, 1'b1);
        repeat (5) step();
        dat_i = 4'b0000;
        repeat (4) step();
        burst(8'b11_10_01_00);
        burst(8'b11_10_01_00);
        dat_i = 4'b0010;
        sb_push(2'd1, 1'b1);
        repeat (5) step();
        dat_i = 4'b0000;
        repeat (4) step();
        burst(8'b01_00_11_10);

        // Back-pressure: ch1 toggles 1,0,1 with both edges enabled.
        edge_sel  = 8'b00_00_11_00;
        evt_ready = 1'b0;
        repeat (2) step();
        dat_i[1] = 1'b1; step();
        dat_i[1] = 1'b0; step();
        dat_i[1] = 1'b1; step();
        step();
        chk("bp_valid", evt_valid, 1);
        chk("bp_ch", evt_ch, 1);
        chk("bp_rise", evt_rise, 1);
        chk("bp_pend", pend_o, 4'b0010);
        chk("bp_ovf_before", ovf_o, 0);
        step();
        chk("bp_ovf", ovf_o, 4'b0010);
        repeat (3) step();
        chk("bp_hold_valid", evt_valid, 1);
        chk("bp_hold_rise", evt_rise, 1);
        chk("bp_hold_ch", evt_ch, 1);
        sb_push(2'd1, 1'b1);
        sb_push(2'd1, 1'b0);
        evt_ready = 1'b1;
        repeat (4) step();
        chk("bp_drained_pend", pend_o, 0);
        chk("bp_drained_valid", evt_valid, 0);
        chk("bp_ovf_sticky", ovf_o, 4'b0010);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf_clr", ovf_o, 0);

        // ovf_clr in the same cycle as a fresh ch3 overflow: overflow wins.
        edge_sel  = 8'b11_00_00_00;
        evt_ready = 1'b0;
        dat_i[3] = 1'b1; step();
        dat_i[3] = 1'b0; step();
        dat_i[3] = 1'b1; step();
        step();
        chk("race_ovf_before", ovf_o, 0);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("race_ovf", ovf_o, 4'b1000);
        sb_push(2'd3, 1'b1);
        sb_push(2'd3, 1'b0);
        evt_ready = 1'b1;
        repeat (4) step();
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("race_ovf_cleared", ovf_o, 0);
        edge_sel = '0;
        dat_i    = '0;
        repeat (4) step();

        // Reset with an event presented and pend=1010.
        edge_sel  = 8'b01_01_01_01;
        evt_ready = 1'b0;
        dat_i     = 4'b1011;
        repeat (4) step();
        chk("rst_pre_valid", evt_valid, 1);
        chk("rst_pre_ch", evt_ch, 0);
        chk("rst_pre_pend", pend_o, 4'b1010);
        #2;
        rstn      = 1'b0;
        edge_sel  = 8'b01_00_00_00;
        evt_ready = 1'b1;
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_pend", pend_o, 0);
        chk("rst_ovf", ovf_o, 0);
        @(posedge clk);
        #2 rstn = 1'b1;
        sb_push(2'd3, 1'b1);
        repeat (10) step();

        for (int t = 0; t < 20 && sb_q.size() != 0; t++) step();
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
